// File: rtl/ex_stage_reg_pkg.sv
// Shared definitions for the execute stage: ALU operation codes,
// forwarding-select encodings and default datapath widths.
// No logic; imported by ex_stage_reg and ex_stage_reg_alu_core.
package ex_stage_reg_pkg;

   localparam int DEFAULT_DATA_W     = 32;
   localparam int DEFAULT_REG_ADDR_W = 5;

   // ALU operation codes as produced by alu_control
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   // Forward-select encodings; 2'b11 is reserved and treated as FWD_IDEX
   localparam logic [1:0] FWD_IDEX  = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/ex_stage_reg_alu_core.sv
// Purpose: combinational MIPS ALU (AND/OR/ADD/SUB/SLT/NOR), unknown codes give 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the owning pipeline register handles stall/flush.
// Ports: a, b operands; operation code; result, zero (result == 0),
//        overflow (signed overflow of ADD/SUB only).
module ex_stage_reg_alu_core
   import ex_stage_reg_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        operation,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic              add_ovf;
   logic              sub_ovf;
   logic              slt;

   assign sum  = a + b;
   assign diff = a - b;

   // Signed overflow: ADD when operands share a sign the result lacks;
   // SUB when operand signs differ and the result sign departs from a.
   assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
   assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
   assign slt     = $signed(a) < $signed(b);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (operation)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: begin
            result   = sum;
            overflow = add_ovf;
         end
         OP_SUB: begin
            result   = diff;
            overflow = sub_ovf;
         end
         OP_SLT: result = {{(DATA_W-1){1'b0}}, slt};
         OP_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_reg.sv
// Purpose: MIPS execute stage - operand forwarding, ALU, EX/MEM pipeline register.
// Latency: 1 cycle from ID/EX inputs to EX/MEM outputs.
// Backpressure: stall holds every output; flush loads a bubble and beats stall.
// Ports: clk/rstn (synchronous, active-low); stall/flush from hazard unit;
//        ID/EX operands, immediate, forward selects, memwb_data, rd and
//        controls in; registered result/zero/store data/rd/controls/overflow out.
// Option: define EX_OVERFLOW_TRAP_EN to flag signed ADD/SUB overflow and
//         suppress the instruction's register and memory writes.
module ex_stage_reg
   import ex_stage_reg_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [3:0]            operation,
   input  logic [DATA_W-1:0]     rs_data,
   input  logic [DATA_W-1:0]     rt_data,
   input  logic [DATA_W-1:0]     imm,
   input  logic                  alu_src,
   input  logic [1:0]            forward_a,
   input  logic [1:0]            forward_b,
   input  logic [DATA_W-1:0]     memwb_data,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  reg_write_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_result,
   output logic                  out_zero,
   output logic [DATA_W-1:0]     out_store_data,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_overflow
);

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_rt;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_ovf;
   logic              trap;

   // Forwarding: the EX/MEM source is this stage's own registered result.
   always_comb begin
      case (forward_a)
         FWD_EXMEM: fwd_a = out_result;
         FWD_MEMWB: fwd_a = memwb_data;
         default:   fwd_a = rs_data;
      endcase
      case (forward_b)
         FWD_EXMEM: fwd_rt = out_result;
         FWD_MEMWB: fwd_rt = memwb_data;
         default:   fwd_rt = rt_data;
      endcase
   end

   assign alu_b = alu_src ? imm : fwd_rt;

   ex_stage_reg_alu_core #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a         (fwd_a),
      .b         (alu_b),
      .operation (operation),
      .result    (alu_result),
      .zero      (alu_zero),
      .overflow  (alu_ovf)
   );

`ifdef EX_OVERFLOW_TRAP_EN
   assign trap = alu_ovf;
`else
   logic unused_alu_ovf;
   assign unused_alu_ovf = alu_ovf;
   assign trap           = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_zero       <= 1'b0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_reg_write  <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_overflow   <= 1'b0;
      end else if (!stall) begin
         // Data fields load even for an invalid slot; only controls are gated.
         out_valid      <= in_valid;
         out_result     <= alu_result;
         out_zero       <= alu_zero;
         out_store_data <= fwd_rt;
         out_rd         <= rd_in;
         out_reg_write  <= in_valid & reg_write_in & ~trap;
         out_mem_read   <= in_valid & mem_read_in;
         out_mem_write  <= in_valid & mem_write_in & ~trap;
         out_overflow   <= trap;
      end
   end

endmodule

// File: tb/tb_ex_stage_reg.sv
// Self-checking bench for ex_stage_reg: directed test-plan steps followed by
// randomized traffic, each cycle compared against a behavioural model.
module tb_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rstn, stall, flush, in_valid, alu_src;
   logic [3:0]  operation;
   logic [31:0] rs_data, rt_data, imm, memwb_data;
   logic [1:0]  forward_a, forward_b;
   logic [4:0]  rd_in;
   logic        reg_write_in, mem_read_in, mem_write_in;
   logic        out_valid, out_zero, out_reg_write, out_mem_read, out_mem_write, out_overflow;
   logic [31:0] out_result, out_store_data;
   logic [4:0]  out_rd;

   int vectors = 0;
   int errors  = 0;

   // Model of the EX/MEM register contents
   logic        m_valid, m_zero, m_rw, m_mr, m_mw, m_ovf;
   logic [31:0] m_result, m_store;
   logic [4:0]  m_rd;

   ex_stage_reg dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .in_valid(in_valid),
      .operation(operation), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
      .alu_src(alu_src), .forward_a(forward_a), .forward_b(forward_b),
      .memwb_data(memwb_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero),
      .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_overflow(out_overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   // Overflow judged on exact integer arithmetic, then range-checked.
   function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 4'd2)      s = sa + sb;
      else if (op == 4'd6) s = sa - sb;
      else                 return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] base);
      if (sel == 2'b10)      return m_result;
      else if (sel == 2'b01) return memwb_data;
      else                   return base;
   endfunction

   task automatic model_edge();
      logic [31:0] a, rt, b, r;
      logic        trap;
      if (!rstn || flush) begin
         {m_valid, m_zero, m_rw, m_mr, m_mw, m_ovf} = '0;
         m_result = 0; m_store = 0; m_rd = 0;
      end else if (!stall) begin
         a  = ref_fwd(forward_a, rs_data);
         rt = ref_fwd(forward_b, rt_data);
         b  = alu_src ? imm : rt;
         r  = ref_alu(operation, a, b);
`ifdef EX_OVERFLOW_TRAP_EN
         trap = ref_ovf(operation, a, b);
`else
         trap = 1'b0;
`endif
         m_valid  = in_valid;
         m_result = r;
         m_zero   = (r == 0);
         m_store  = rt;
         m_rd     = rd_in;
         m_rw     = in_valid && reg_write_in && !trap;
         m_mr     = in_valid && mem_read_in;
         m_mw     = in_valid && mem_write_in && !trap;
         m_ovf    = trap;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("valid",     {31'd0, out_valid},     {31'd0, m_valid});
      check("result",    out_result,             m_result);
      check("zero",      {31'd0, out_zero},      {31'd0, m_zero});
      check("store",     out_store_data,         m_store);
      check("rd",        {27'd0, out_rd},        {27'd0, m_rd});
      check("reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
      check("mem_read",  {31'd0, out_mem_read},  {31'd0, m_mr});
      check("mem_write", {31'd0, out_mem_write}, {31'd0, m_mw});
      check("overflow",  {31'd0, out_overflow},  {31'd0, m_ovf});
   endtask

   // Apply current inputs across one rising edge, then compare #1 later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      rstn = 1; stall = 0; flush = 0; in_valid = 0; operation = 4'd0;
      rs_data = 0; rt_data = 0; imm = 0; alu_src = 0; forward_a = 0; forward_b = 0;
      memwb_data = 0; rd_in = 0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return $urandom_range(0, 8);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] ops [8];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
      {m_valid, m_zero, m_rw, m_mr, m_mw, m_ovf} = '0;
      m_result = 0; m_store = 0; m_rd = 0;

      // Reset with live inputs: everything must clear
      idle_inputs();
      @(negedge clk);
      rstn = 0; in_valid = 1; operation = 4'd2; rs_data = 9; reg_write_in = 1; rd_in = 5'd3;
      tick();
      check("rst_result", out_result, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);

      // ADD 5+7
      idle_inputs();
      in_valid = 1; operation = 4'd2; rs_data = 5; rt_data = 7; rd_in = 5'd8; reg_write_in = 1;
      tick();
      check("add_5_7", out_result, 32'd12);
      check("add_valid", {31'd0, out_valid}, 32'd1);

      // Back-to-back dependency through EX/MEM forwarding
      rs_data = 3; rt_data = 4;
      tick();
      check("add_3_4", out_result, 32'd7);
      operation = 4'd6; forward_a = 2'b10; rs_data = 32'd99; rt_data = 7;
      tick();
      check("sub_fwd", out_result, 32'd0);
      check("sub_zero", {31'd0, out_zero}, 32'd1);

      // MEM/WB forward on rt path, SLT 0 < -1 is false
      forward_a = 2'b00; forward_b = 2'b01; memwb_data = 32'hFFFFFFFF; rs_data = 0;
      rt_data = 32'h55; operation = 4'd7;
      tick();
      check("slt_res", out_result, 32'd0);
      check("slt_store", out_store_data, 32'hFFFFFFFF);

      // Stall for 3 cycles with changing inputs
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         operation = ops[$urandom_range(0, 7)]; rs_data = $urandom; rt_data = $urandom;
         forward_b = 2'($urandom); rd_in = 5'($urandom);
         tick();
         check("stall_store", out_store_data, 32'hFFFFFFFF);
      end
      // Stall and flush together: bubble
      flush = 1; mem_read_in = 1; reg_write_in = 1;
      tick();
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_rw", {31'd0, out_reg_write}, 32'd0);

      // Immediate operand with store
      idle_inputs();
      in_valid = 1; operation = 4'd2; alu_src = 1; imm = 32'hFFFFFFFC; rs_data = 32'h10;
      rt_data = 32'hCAFE0001; mem_write_in = 1;
      tick();
      check("imm_result", out_result, 32'h0000000C);
      check("imm_mw", {31'd0, out_mem_write}, 32'd1);
      check("imm_store", out_store_data, 32'hCAFE0001);

      // Signed overflow on ADD
      idle_inputs();
      in_valid = 1; operation = 4'd2; rs_data = 32'h7FFFFFFF; rt_data = 1; reg_write_in = 1;
      tick();
      check("ovf_result", out_result, 32'h80000000);
`ifdef EX_OVERFLOW_TRAP_EN
      check("ovf_flag", {31'd0, out_overflow}, 32'd1);
      check("ovf_rw", {31'd0, out_reg_write}, 32'd0);
`else
      check("ovf_flag", {31'd0, out_overflow}, 32'd0);
      check("ovf_rw", {31'd0, out_reg_write}, 32'd1);
`endif

      // Invalid slot: data loads, controls suppressed
      in_valid = 0; operation = 4'd1; rs_data = 32'hF0; rt_data = 32'h0F; mem_read_in = 1;
      tick();
      check("inv_result", out_result, 32'hFF);
      check("inv_mr", {31'd0, out_mem_read}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rstn         = ($urandom_range(0, 39) != 0);
         stall        = ($urandom_range(0, 5) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         in_valid     = ($urandom_range(0, 4) != 0);
         operation    = ops[$urandom_range(0, 7)];
         rs_data      = rand_word();
         rt_data      = rand_word();
         imm          = rand_word();
         memwb_data   = rand_word();
         alu_src      = 1'($urandom);
         forward_a    = 2'($urandom);
         forward_b    = 2'($urandom);
         rd_in        = 5'($urandom);
         reg_write_in = 1'($urandom);
         mem_read_in  = 1'($urandom);
         mem_write_in = 1'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
